// File: rtl/uart_tx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_mmio : memory-mapped 8N1 UART transmitter with TX FIFO and drain IRQ
// Revision     : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_en_q, irq_en_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic        wr_en, push_req, push_ok, pop, empty, full, bit_end, busy;
  logic [1:0]  reg_sel;
  logic [15:0] div_new;
  logic [31:0] count_ext, status, rdata;
  logic [3:0]  count_sat;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

  assign wr_en    = ce & we;
  assign reg_sel  = addr[3:2];
  assign push_req = wr_en && (reg_sel == 2'd0) && sel[0];
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign push_ok  = push_req && (!full || pop);
  assign busy     = (state_q != S_IDLE);
  assign bit_end  = (bit_cnt_q >= div_q - 16'd1);

  // Serialiser next-state; a pop loads the shift register from the FIFO head.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 16'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = 16'd0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: ;
    endcase
  end

  // Register writes; an overflow event at the same edge as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    div_d      = div_q;
    div_new    = {sel[1] ? data_i[15:8] : div_q[15:8],
                  sel[0] ? data_i[7:0]  : div_q[7:0]};
    if (wr_en && (reg_sel == 2'd2) && sel[0]) begin
      irq_en_d = data_i[0];
      if (data_i[1]) overflow_d = 1'b0;
    end
    if (push_req && full && !pop) overflow_d = 1'b1;
    if (wr_en && (reg_sel == 2'd3)) begin
      div_d = (div_new == 16'd0) ? 16'd1 : div_new;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= DEFAULT_DIV;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      div_q      <= div_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i[7:0];
  end

  always_comb begin
    count_ext = 32'(count_q);
    count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status    = {24'h0, count_sat, overflow_q, empty, full, busy};
    rdata     = 32'h0;
    case (reg_sel)
      2'd1:    rdata = status;
      2'd2:    rdata = {31'h0, irq_en_q};
      2'd3:    rdata = {16'h0, div_q};
      default: rdata = 32'h0;
    endcase
    data_o = (ce && !we) ? rdata : 32'h0;
  end

  assign irq_o = irq_en_q & empty & ~busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_mmio : directed and randomised bench with a frame-level model
// Revision        : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DDIV  = 16'd434;

  logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'h0, data_i = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data_o;
  logic        tx_o, irq_o;

  int checks = 0, passed = 0, cyc = 0;
  bit m_valid = 1'b0;

  // Model: a byte queue plus the frame in flight, tracked as elapsed cycles.
  logic [7:0]  m_q[$];
  logic [15:0] m_div, nd;
  bit          m_ovf, m_irq_en, m_active;
  int          m_t, m_fdiv;
  logic [7:0]  m_fb;

  always #5 clk = ~clk;

  uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / m_fdiv;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_fb[b-1];
  endfunction

  function automatic logic [31:0] exp_status();
    int n = m_q.size();
    logic [3:0] s = (n > 15) ? 4'hF : 4'(n);
    return {24'h0, s, m_ovf, (n == 0), (n == DEPTH), m_active};
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!ce || we) return 32'h0;
    case (addr[3:2])
      2'd1:    return exp_status();
      2'd2:    return {31'h0, m_irq_en};
      2'd3:    return {16'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  task automatic start_frame();
    m_fb     = m_q.pop_front();
    m_fdiv   = int'(m_div);
    m_t      = 0;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_irq_en = 0; m_active = 0; m_t = 0; m_fdiv = 1;
      m_div = DDIV;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_active) begin
        if (m_q.size() > 0) start_frame();
      end else if (m_t == 10 * m_fdiv - 1) begin
        if (m_q.size() > 0) start_frame();
        else m_active = 1'b0;
      end else begin
        m_t++;
      end
      if (ce && we) begin
        case (addr[3:2])
          2'd0: if (sel[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back(data_i[7:0]);
            else m_ovf = 1'b1;
          end
          2'd2: if (sel[0]) begin
            m_irq_en = data_i[0];
            if (data_i[1]) m_ovf = 1'b0;
          end
          2'd3: if (sel[0] || sel[1]) begin
            nd[15:8] = sel[1] ? data_i[15:8] : m_div[15:8];
            nd[7:0]  = sel[0] ? data_i[7:0]  : m_div[7:0];
            m_div = (nd == 16'd0) ? 16'd1 : nd;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_o", {31'h0, tx_o}, {31'h0, exp_tx()});
      chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq_en && (m_q.size() == 0) && !m_active});
      chk("data_o", data_o, exp_rdata());
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] ad = $urandom;
    ad[3:2] = a;
    addr = ad; data_i = d; sel = s; ce = 1'b1; we = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] ad = $urandom;
    ad[3:2] = a;
    addr = ad; ce = 1'b1; we = 1'b0;
    #2;
    chk(name, data_o, exp);
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic peek();
    addr = $urandom; ce = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  initial begin
    logic [9:0]  fr;
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] dv;
    int n0, lows, tr, r, rpt;
    bit got;

    step(2);
    rst = 1'b0;
    chk("reset tx_o", {31'h0, tx_o}, 32'h1);
    chk("reset irq_o", {31'h0, irq_o}, 32'h0);
    rd(2'd1, 32'h4, "reset STATUS");
    rd(2'd2, 32'h0, "reset CTRL");
    rd(2'd3, 32'd434, "reset DIVISOR");
    rd(2'd0, 32'h0, "TXDATA reads 0");

    // 0x55 at DIVISOR=4: start, LSB-first data, stop, 4 cycles each.
    wr(2'd3, 32'd4, 4'hF);
    wr(2'd0, 32'h55, 4'hF);
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      chk("frame55 tx", {31'h0, tx_o}, {31'h0, fr[k/4]});
    end
    @(posedge clk); #1;
    rd(2'd1, 32'h4, "idle after frame55");

    // Three queued bytes at DIVISOR=2 with the drain interrupt enabled.
    wr(2'd2, 32'h1, 4'h1);
    wr(2'd3, 32'd2, 4'h3);
    wr(2'd0, 32'hA5, 4'h1);
    n0 = cyc;
    wr(2'd0, 32'h3C, 4'h1);
    wr(2'd0, 32'hFF, 4'h1);
    rd(2'd1, 32'h21, "count peak status");
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #2;
      if (irq_o) got = 1'b1;
    end
    chk("irq rise edge after first push", 32'(cyc - n0), 32'd61);

    // Overflow: 10 writes into an 8-deep FIFO behind a slow frame.
    wr(2'd2, 32'h0, 4'h1);
    wr(2'd3, 32'd1000, 4'h3);
    for (int i = 0; i < 10; i++) wr(2'd0, 32'(i + 1), 4'h1);
    rd(2'd1, 32'h8B, "full and overflow");
    wr(2'd2, 32'h2, 4'h1);
    rd(2'd1, 32'h83, "overflow cleared");
    rd(2'd2, 32'h0, "CTRL bit1 reads 0");
    rst = 1'b1; step(1); rst = 1'b0;
    rd(2'd1, 32'h4, "flushed by reset");

    // A push without sel[0] is dropped.
    wr(2'd0, 32'h77, 4'b1000);
    rd(2'd1, 32'h4, "sel1000 no push");

    // DIVISOR=0 stores 1: one 10-cycle frame with nine low bit-times.
    wr(2'd3, 32'h0, 4'hF);
    rd(2'd3, 32'h1, "div0 reads 1");
    wr(2'd0, 32'h0, 4'h1);
    lows = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      if (!tx_o) lows++;
    end
    chk("div1 frame low cycles", 32'(lows), 32'd9);

    // Reset in the middle of the data bits with three bytes queued.
    step(1);
    wr(2'd3, 32'd4, 4'h3);
    wr(2'd0, 32'h11, 4'h1);
    wr(2'd0, 32'h22, 4'h1);
    wr(2'd0, 32'h33, 4'h1);
    wr(2'd0, 32'h44, 4'h1);
    step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("tx after mid-frame reset", {31'h0, tx_o}, 32'h1);
    rd(2'd1, 32'h4, "status after mid-frame reset");
    tr = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (tx_o !== 1'b1) tr++;
    end
    chk("no tx activity after reset", 32'(tr), 32'd0);

    // Randomised traffic; DIVISOR only changes while nothing is in flight.
    for (int p = 0; p < 6; p++) begin
      dv = 16'(p % 3 + 1);
      rst = 1'b1; step(1); rst = 1'b0;
      wr(2'd3, {16'h0, dv}, 4'h3);
      rpt = $urandom_range(50, 450);
      for (int i = 0; i < 500; i++) begin
        r = $urandom_range(0, 99);
        if (i == rpt) begin
          rst = 1'b1; step(1); rst = 1'b0;
          wr(2'd3, {16'h0, dv}, 4'h3);
        end else if (r < 40) begin
          s = 4'($urandom);
          if (r < 34) s[0] = 1'b1;
          wr(2'd0, $urandom, s);
        end else if (r < 50) begin
          peek();
        end else if (r < 57) begin
          wr(2'd2, $urandom, 4'($urandom));
        end else if (r < 62) begin
          if (!m_active && m_q.size() == 0) begin
            d = $urandom;
            d[15:0] = 16'($urandom_range(0, 3));
            wr(2'd3, d, 4'($urandom));
          end else begin
            step(1);
          end
        end else if (r < 65) begin
          wr(2'd1, $urandom, 4'($urandom));
        end else begin
          step(1);
        end
      end
    end

    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
